// File: rtl/pipeline_hazard_unit_if.sv
// Bundle between the pipeline control path and the hazard/forwarding unit:
// ID-stage operand info and redirect in, forwarding selects and stall/flush controls out.
interface pipeline_hazard_unit_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              enable;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic [ADDR_W-1:0] id_waddr;
  logic              id_mem_read;
  logic              mem_redirect;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_exe_flush;
  logic              exe_mem_flush;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_waddr, id_mem_read, mem_redirect,
    input  fwd_a, fwd_b, pc_en, if_id_en, if_id_flush, id_exe_flush,
           exe_mem_flush, stall_count
  );

  modport slave (
    input  enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_write, id_waddr, id_mem_read, mem_redirect,
    output fwd_a, fwd_b, pc_en, if_id_en, if_id_flush, id_exe_flush,
           exe_mem_flush, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadows EXE/MEM/WB,
// selects EXE operand forwarding, inserts load-use bubbles and flushes on MEM redirects.
module pipeline_hazard_unit #(
  parameter int ADDR_W      = 5,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   arst,
  pipeline_hazard_unit_if.slave bus
);

  // Later stages keep only the fields still consulted downstream of them.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic              mem_read;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
  } exe_slot_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic              mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
  } wb_slot_t;

  localparam bit FLUSH_EXE = (FLUSH_DEPTH >= 2);
  localparam bit FLUSH_MEM = (FLUSH_DEPTH >= 3);

  exe_slot_t        exe_q;
  exe_slot_t        id_slot;
  mem_slot_t        mem_q;
  wb_slot_t         wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic exe_writing;
  logic mem_writing;
  logic wb_writing;
  logic load_use;
  logic redirect;
  logic stall;

  function automatic logic [1:0] fwd_sel(
    input logic              uses,
    input logic [ADDR_W-1:0] src,
    input logic              mem_wr,
    input mem_slot_t         m,
    input logic              wb_wr,
    input wb_slot_t          w
  );
    logic [1:0] sel;
    sel = 2'b00;
    // A load still in MEM has no data yet; the load-use bubble covers that case.
    if (uses && mem_wr && (m.waddr == src) && !m.mem_read)
      sel = 2'b01;
    else if (wb_wr && (w.waddr == src))
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    id_slot = exe_slot_t'{
      valid:     bus.id_valid,
      reg_write: bus.id_reg_write,
      waddr:     bus.id_waddr,
      mem_read:  bus.id_mem_read,
      rs:        bus.id_rs,
      rt:        bus.id_rt,
      uses_rs:   bus.id_uses_rs,
      uses_rt:   bus.id_uses_rt
    };
    exe_writing = exe_q.valid & exe_q.reg_write & (exe_q.waddr != '0);
    mem_writing = mem_q.valid & mem_q.reg_write & (mem_q.waddr != '0);
    wb_writing  = wb_q.valid  & wb_q.reg_write  & (wb_q.waddr  != '0);
    load_use    = bus.id_valid & exe_q.mem_read & exe_writing &
                  ((bus.id_uses_rs & (bus.id_rs == exe_q.waddr)) |
                   (bus.id_uses_rt & (bus.id_rt == exe_q.waddr)));
    redirect    = bus.enable & bus.mem_redirect;
    stall       = bus.enable & load_use & ~redirect;
  end

  always_comb begin
    bus.fwd_a         = fwd_sel(exe_q.uses_rs, exe_q.rs, mem_writing, mem_q, wb_writing, wb_q);
    bus.fwd_b         = fwd_sel(exe_q.uses_rt, exe_q.rt, mem_writing, mem_q, wb_writing, wb_q);
    bus.pc_en         = bus.enable & ~stall;
    bus.if_id_en      = bus.enable & ~stall;
    bus.if_id_flush   = redirect;
    bus.id_exe_flush  = stall | (redirect & FLUSH_EXE);
    bus.exe_mem_flush = redirect & FLUSH_MEM;
    bus.stall_count   = cnt_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (bus.enable) begin
      wb_q  <= wb_slot_t'{valid: mem_q.valid, reg_write: mem_q.reg_write, waddr: mem_q.waddr};
      mem_q <= (redirect && FLUSH_MEM) ? mem_slot_t'('0) :
               mem_slot_t'{valid: exe_q.valid, reg_write: exe_q.reg_write,
                            waddr: exe_q.waddr, mem_read: exe_q.mem_read};
      exe_q <= (stall || (redirect && FLUSH_EXE)) ? exe_slot_t'('0) : id_slot;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: a depth-3/16-bit instance and a depth-1/4-bit instance
// share stimulus and are compared against an instruction-level pipeline model.
module tb_pipeline_hazard_unit;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic          enable, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, mem_redirect;
  logic [AW-1:0] id_rs, id_rt, id_waddr;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_unit_if #(.ADDR_W(AW), .CNT_W(16)) bus0 ();
  pipeline_hazard_unit_if #(.ADDR_W(AW), .CNT_W(4))  bus1 ();

  assign bus0.enable = enable;             assign bus1.enable = enable;
  assign bus0.id_valid = id_valid;         assign bus1.id_valid = id_valid;
  assign bus0.id_rs = id_rs;               assign bus1.id_rs = id_rs;
  assign bus0.id_rt = id_rt;               assign bus1.id_rt = id_rt;
  assign bus0.id_uses_rs = id_uses_rs;     assign bus1.id_uses_rs = id_uses_rs;
  assign bus0.id_uses_rt = id_uses_rt;     assign bus1.id_uses_rt = id_uses_rt;
  assign bus0.id_reg_write = id_reg_write; assign bus1.id_reg_write = id_reg_write;
  assign bus0.id_waddr = id_waddr;         assign bus1.id_waddr = id_waddr;
  assign bus0.id_mem_read = id_mem_read;   assign bus1.id_mem_read = id_mem_read;
  assign bus0.mem_redirect = mem_redirect; assign bus1.mem_redirect = mem_redirect;

  pipeline_hazard_unit #(.ADDR_W(AW), .FLUSH_DEPTH(3), .CNT_W(16)) u0 (
    .clk(clk), .arst(arst), .bus(bus0.slave));
  pipeline_hazard_unit #(.ADDR_W(AW), .FLUSH_DEPTH(1), .CNT_W(4)) u1 (
    .clk(clk), .arst(arst), .bus(bus1.slave));

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {
    bit valid, rw, mr, urs, urt;
    int wa, rs, rt;
  } instr_t;

  instr_t pipe [2][3];          // [instance][0=EXE,1=MEM,2=WB]
  int     cnt  [2];
  int     depth[2] = '{3, 1};
  int     cmax [2] = '{65535, 15};

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic instr_t id_instr();
    instr_t i;
    i.valid = id_valid;  i.rw = id_reg_write; i.mr = id_mem_read;
    i.urs = id_uses_rs;  i.urt = id_uses_rt;
    i.wa = int'(id_waddr); i.rs = int'(id_rs); i.rt = int'(id_rt);
    return i;
  endfunction

  function automatic bit produces(instr_t i);
    return i.valid && i.rw && (i.wa != 0);
  endfunction

  function automatic bit m_load_use(int k);
    instr_t e;
    e = pipe[k][0];
    return id_valid && e.mr && produces(e) &&
           ((id_uses_rs && int'(id_rs) == e.wa) || (id_uses_rt && int'(id_rt) == e.wa));
  endfunction

  function automatic logic [1:0] m_fwd(int k, bit uses, int src);
    if (uses && produces(pipe[k][1]) && pipe[k][1].wa == src && !pipe[k][1].mr) return 2'b01;
    if (produces(pipe[k][2]) && pipe[k][2].wa == src) return 2'b10;
    return 2'b00;
  endfunction

  // {fwd_a, fwd_b, pc_en, if_id_en, if_id_flush, id_exe_flush, exe_mem_flush}
  function automatic logic [8:0] m_out(int k);
    bit redir, stall, adv;
    redir = enable && mem_redirect;
    stall = enable && m_load_use(k) && !redir;
    adv   = enable && !stall;
    return {m_fwd(k, pipe[k][0].urs, pipe[k][0].rs), m_fwd(k, pipe[k][0].urt, pipe[k][0].rt),
            adv, adv, redir, stall || (redir && depth[k] >= 2), redir && depth[k] >= 3};
  endfunction

  function automatic logic [8:0] dut_out(int k);
    if (k == 0)
      return {bus0.fwd_a, bus0.fwd_b, bus0.pc_en, bus0.if_id_en,
              bus0.if_id_flush, bus0.id_exe_flush, bus0.exe_mem_flush};
    return {bus1.fwd_a, bus1.fwd_b, bus1.pc_en, bus1.if_id_en,
            bus1.if_id_flush, bus1.id_exe_flush, bus1.exe_mem_flush};
  endfunction

  function automatic int dut_cnt(int k);
    return (k == 0) ? int'(bus0.stall_count) : int'(bus1.stall_count);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = bubble();
      cnt[k] = 0;
    end
  endtask

  // One clock: compute next model state from current inputs, cross the edge, settle.
  task automatic tick();
    instr_t nxt[2][3];
    int     ncnt[2];
    bit     redir, stall;
    for (int k = 0; k < 2; k++) begin
      redir = enable && mem_redirect;
      stall = enable && m_load_use(k) && !redir;
      for (int s = 0; s < 3; s++) nxt[k][s] = pipe[k][s];
      ncnt[k] = cnt[k];
      if (enable) begin
        nxt[k][2] = pipe[k][1];
        nxt[k][1] = (redir && depth[k] >= 3) ? bubble() : pipe[k][0];
        nxt[k][0] = (stall || (redir && depth[k] >= 2)) ? bubble() : id_instr();
        if (stall && cnt[k] < cmax[k]) ncnt[k] = cnt[k] + 1;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = nxt[k][s];
      cnt[k] = ncnt[k];
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit rw, input int wa, input bit mr);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_waddr = AW'(wa); id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    enable = 1'b1; mem_redirect = 1'b0;
    nop();
    repeat (3) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b0; enable = 1'b1; mem_redirect = 1'b0;
    nop();
    model_reset();
    #1 arst = 1'b1;
    @(negedge clk); #1;
    checks++; if (dut_out(0) !== 9'b00_00_1_1_000) begin errors++; $display("FAIL reset_out0: got %b expected %b", dut_out(0), 9'b00_00_1_1_000); end
    checks++; if (dut_out(1) !== 9'b00_00_1_1_000) begin errors++; $display("FAIL reset_out1: got %b expected %b", dut_out(1), 9'b00_00_1_1_000); end
    checks++; if (bus0.stall_count !== 16'd0) begin errors++; $display("FAIL reset_cnt0: got %0d expected 0", bus0.stall_count); end
    @(negedge clk);
    arst = 1'b0;
    #1;
  endtask

  task automatic test_ex_hazard();
    flush();
    set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();            // add $3,$1,$2
    set_id(1, 3, 5, 1, 1, 1, 4, 0); tick();            // sub $4,$3,$5
    nop(); #1;
    checks++; if (bus0.fwd_a !== 2'b01) begin errors++; $display("FAIL ex_hazard_a: got %b expected 01", bus0.fwd_a); end
    checks++; if (bus0.fwd_b !== 2'b00) begin errors++; $display("FAIL ex_hazard_b: got %b expected 00", bus0.fwd_b); end
    flush();
    set_id(1, 1, 2, 1, 1, 1, 0, 0); tick();            // add $0,$1,$2
    set_id(1, 0, 5, 1, 1, 1, 4, 0); tick();            // sub $4,$0,$5
    nop(); #1;
    checks++; if (bus0.fwd_a !== 2'b00) begin errors++; $display("FAIL ex_hazard_r0: got %b expected 00", bus0.fwd_a); end
  endtask

  task automatic test_double_hazard();
    flush();
    set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();
    set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();
    set_id(1, 3, 3, 1, 1, 1, 6, 0); tick();            // add $6,$3,$3
    nop(); #1;
    checks++; if ({bus0.fwd_a, bus0.fwd_b} !== 4'b0101) begin errors++; $display("FAIL double_mem_wins: got %b expected 0101", {bus0.fwd_a, bus0.fwd_b}); end
    flush();
    set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();
    nop(); tick();
    set_id(1, 3, 3, 1, 1, 1, 6, 0); tick();
    nop(); #1;
    checks++; if ({bus0.fwd_a, bus0.fwd_b} !== 4'b1010) begin errors++; $display("FAIL double_wb: got %b expected 1010", {bus0.fwd_a, bus0.fwd_b}); end
  endtask

  task automatic test_load_use();
    int c;
    flush();
    set_id(1, 1, 2, 1, 0, 1, 2, 1); tick();            // lw $2,0($1)
    set_id(1, 2, 2, 1, 1, 1, 4, 0); #1;                // add $4,$2,$2
    c = cnt[0];
    checks++; if (dut_out(0) !== 9'b00_00_0_0_010) begin errors++; $display("FAIL load_use_stall: got %b expected %b", dut_out(0), 9'b00_00_0_0_010); end
    tick();
    checks++; if (int'(bus0.stall_count) !== c + 1) begin errors++; $display("FAIL load_use_cnt: got %0d expected %0d", bus0.stall_count, c + 1); end
    checks++; if ({bus0.pc_en, bus0.id_exe_flush} !== 2'b10) begin errors++; $display("FAIL load_use_release: got %b expected 10", {bus0.pc_en, bus0.id_exe_flush}); end
    tick();
    nop(); #1;
    checks++; if ({bus0.fwd_a, bus0.fwd_b} !== 4'b1010) begin errors++; $display("FAIL load_use_fwd: got %b expected 1010", {bus0.fwd_a, bus0.fwd_b}); end
  endtask

  task automatic test_back_to_back();
    int c;
    flush();
    c = cnt[0];
    set_id(1, 1, 2, 1, 0, 1, 2, 1); tick();            // lw $2,0($1)
    set_id(1, 2, 3, 1, 0, 1, 3, 1); #1;                // lw $3,0($2)
    checks++; if (bus0.pc_en !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %b expected 0", bus0.pc_en); end
    tick();
    checks++; if (bus0.pc_en !== 1'b1) begin errors++; $display("FAIL b2b_release1: got %b expected 1", bus0.pc_en); end
    tick();
    set_id(1, 3, 3, 1, 1, 1, 4, 0); #1;                // add $4,$3,$3
    checks++; if (bus0.pc_en !== 1'b0) begin errors++; $display("FAIL b2b_stall2: got %b expected 0", bus0.pc_en); end
    tick(); tick();
    nop(); #1;
    checks++; if ({bus0.fwd_a, bus0.fwd_b} !== 4'b1010) begin errors++; $display("FAIL b2b_fwd: got %b expected 1010", {bus0.fwd_a, bus0.fwd_b}); end
    checks++; if (int'(bus0.stall_count) !== c + 2) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", bus0.stall_count, c + 2); end
  endtask

  task automatic test_redirect_priority();
    int c0, c1;
    flush();
    set_id(1, 1, 2, 1, 0, 1, 2, 1); tick();            // lw $2,0($1)
    set_id(1, 2, 2, 1, 1, 1, 4, 0);
    mem_redirect = 1'b1; #1;
    c0 = cnt[0]; c1 = cnt[1];
    checks++; if (dut_out(0) !== 9'b00_00_1_1_111) begin errors++; $display("FAIL redirect_d3: got %b expected %b", dut_out(0), 9'b00_00_1_1_111); end
    checks++; if (dut_out(1) !== 9'b00_00_1_1_100) begin errors++; $display("FAIL redirect_d1: got %b expected %b", dut_out(1), 9'b00_00_1_1_100); end
    tick();
    mem_redirect = 1'b0;
    checks++; if (int'(bus0.stall_count) !== c0) begin errors++; $display("FAIL redirect_cnt0: got %0d expected %0d", bus0.stall_count, c0); end
    checks++; if (int'(bus1.stall_count) !== c1) begin errors++; $display("FAIL redirect_cnt1: got %0d expected %0d", bus1.stall_count, c1); end
    enable = 1'b0; mem_redirect = 1'b1; #1;
    checks++; if (dut_out(0) & 9'b00_00_1_1_111 !== 9'd0) begin errors++; $display("FAIL redirect_disabled: got %b expected ctrl 00000", dut_out(0)); end
    mem_redirect = 1'b0; enable = 1'b1;
  endtask

  task automatic test_saturation();
    int c0;
    flush();
    c0 = cnt[0];
    set_id(1, 2, 0, 1, 0, 1, 2, 1);                    // lw $2,0($2) held in ID
    for (int n = 0; n < 40; n++) begin
      #1;
      checks++; if (dut_out(1) !== m_out(1)) begin errors++; $display("FAIL sat_out cycle %0d: got %b expected %b", n, dut_out(1), m_out(1)); end
      tick();
    end
    checks++; if (bus1.stall_count !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d expected 15", bus1.stall_count); end
    checks++; if (int'(bus0.stall_count) !== c0 + 20) begin errors++; $display("FAIL sat_cnt16: got %0d expected %0d", bus0.stall_count, c0 + 20); end
    enable = 1'b0; mem_redirect = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++; if (dut_out(0) !== m_out(0) || dut_out(0) & 9'b00_00_1_1_111) begin errors++; $display("FAIL freeze_out cycle %0d: got %b expected %b", n, dut_out(0), m_out(0)); end
      checks++; if (bus1.stall_count !== 4'd15 || int'(bus0.stall_count) !== c0 + 20) begin errors++; $display("FAIL freeze_cnt cycle %0d: got %0d/%0d expected 15/%0d", n, bus1.stall_count, bus0.stall_count, c0 + 20); end
      tick();
    end
    mem_redirect = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset_midstream();
    flush();
    set_id(1, 1, 2, 1, 1, 1, 3, 0); tick();
    set_id(1, 3, 3, 1, 1, 1, 5, 0); tick();
    set_id(1, 6, 7, 1, 1, 1, 8, 0); #1;
    checks++; if ({bus0.fwd_a, bus0.fwd_b} !== 4'b0101) begin errors++; $display("FAIL pre_reset_fwd: got %b expected 0101", {bus0.fwd_a, bus0.fwd_b}); end
    arst = 1'b1; #1;
    model_reset();
    checks++; if (dut_out(0) !== 9'b00_00_1_1_000) begin errors++; $display("FAIL midreset_out: got %b expected %b", dut_out(0), 9'b00_00_1_1_000); end
    checks++; if (bus0.stall_count !== 16'd0 || bus1.stall_count !== 4'd0) begin errors++; $display("FAIL midreset_cnt: got %0d/%0d expected 0/0", bus0.stall_count, bus1.stall_count); end
    @(negedge clk);
    arst = 1'b0;
    set_id(0, 3, 3, 1, 1, 1, 3, 0); #1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if ({bus0.fwd_a, bus0.fwd_b} !== 4'b0000) begin errors++; $display("FAIL post_reset_fwd %0d: got %b expected 0000", n, {bus0.fwd_a, bus0.fwd_b}); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable       = ($urandom_range(0, 9) != 0);
      mem_redirect = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 2) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++; if (dut_out(k) !== m_out(k)) begin errors++; $display("FAIL random_out[%0d] cycle %0d: got %b expected %b", k, n, dut_out(k), m_out(k)); end
        checks++; if (dut_cnt(k) !== cnt[k]) begin errors++; $display("FAIL random_cnt[%0d] cycle %0d: got %0d expected %0d", k, n, dut_cnt(k), cnt[k]); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_hazard();
    test_double_hazard();
    test_load_use();
    test_back_to_back();
    test_redirect_priority();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
